// File: rtl/axis_queue_driver_if.sv
// Loader-side push port and AXIS master port of the beat-queue driver, grouped as one bundle.
// A transfer happens on a clk edge where valid & ready; valid never waits on ready, and once valid is up it and its payload hold until that transfer.
interface axis_queue_driver_if #(
    parameter int DATA_BYTES = 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
);
    logic                    push_valid;
    logic                    push_ready;
    logic [DATA_BYTES*8-1:0] push_data;
    logic                    push_last;
    logic [DATA_BYTES-1:0]   push_keep;
    logic [DATA_BYTES-1:0]   push_strb;
    logic [ID_WIDTH-1:0]     push_id;
    logic [DEST_WIDTH-1:0]   push_dest;
    logic [USER_WIDTH-1:0]   push_user;

    logic                    m_tvalid;
    logic                    m_tready;
    logic [DATA_BYTES*8-1:0] m_tdata;
    logic                    m_tlast;
    logic [DATA_BYTES-1:0]   m_tkeep;
    logic [DATA_BYTES-1:0]   m_tstrb;
    logic [ID_WIDTH-1:0]     m_tid;
    logic [DEST_WIDTH-1:0]   m_tdest;
    logic [USER_WIDTH-1:0]   m_tuser;

    modport master (
        input  push_valid, push_data, push_last, push_keep, push_strb,
               push_id, push_dest, push_user, m_tready,
        output push_ready, m_tvalid, m_tdata, m_tlast, m_tkeep, m_tstrb,
               m_tid, m_tdest, m_tuser
    );

    modport slave (
        output push_valid, push_data, push_last, push_keep, push_strb,
               push_id, push_dest, push_user, m_tready,
        input  push_ready, m_tvalid, m_tdata, m_tlast, m_tkeep, m_tstrb,
               m_tid, m_tdest, m_tuser
    );
endinterface

// File: rtl/axis_queue_driver.sv
// Beat-queue AXIS source: loader beats go into a FIFO and are replayed in order on a
// registered AXIS master output, with a count of tlast beats accepted downstream.
module axis_queue_driver #(
    parameter int DATA_BYTES = 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    axis_queue_driver_if.master      bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              pkt_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = DATA_BYTES*8 + 1 + 2*DATA_BYTES + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   mem_count;
    logic [BW-1:0] out_beat;
    logic          out_valid;
    logic [BW-1:0] push_beat;
    logic          push_fire;
    logic          pop_fire;
    logic          load;

    assign push_beat = {bus.push_data, bus.push_last, bus.push_keep, bus.push_strb,
                        bus.push_id, bus.push_dest, bus.push_user};

    // level counts the presented beat too, so capacity is DEPTH beats in total
    // even though mem plus the output register could hold one more.
    assign bus.push_ready = (level < LEVEL_MAX);
    assign push_fire      = bus.push_valid & bus.push_ready;
    assign pop_fire       = out_valid & bus.m_tready;
    // A new head beat is presented only when enabled and the output slot is free
    // or being emptied this edge; a held beat is never withdrawn.
    assign load           = enable & (mem_count != '0) & (~out_valid | bus.m_tready);

    assign bus.m_tvalid = out_valid;
    assign {bus.m_tdata, bus.m_tlast, bus.m_tkeep, bus.m_tstrb,
            bus.m_tid, bus.m_tdest, bus.m_tuser} = out_beat;

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push_beat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_beat  <= '0;
            out_valid <= 1'b0;
            level     <= '0;
            pkt_count <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                out_beat <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            out_valid <= load | (out_valid & ~bus.m_tready);

            case ({push_fire, load})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase

            case ({push_fire, pop_fire})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (pop_fire & bus.m_tlast) pkt_count <= pkt_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_axis_queue_driver.sv
// Randomized bench for axis_queue_driver: a queue model of pushed beats checks every
// accepted output beat, the level, push_ready, pkt_count, hold stability and enable gating.
module tb_axis_queue_driver;
    localparam int DB    = 8;
    localparam int DEPTH = 256;
    localparam int W     = DB*8 + 1 + 2*DB + 8 + 8 + 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [8:0]  level;
    logic [31:0] pkt_count;

    axis_queue_driver_if #(.DATA_BYTES(DB), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(8)) bus ();

    axis_queue_driver #(
        .DATA_BYTES(DB), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(8), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus.master),
        .level(level), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;
    bit rand_ready = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: beats pushed but not yet accepted, in push order.
    logic [W-1:0] exp_q[$];
    int           n_push = 0;
    int           n_pop = 0;
    logic [31:0]  model_pkts = '0;
    bit           armed = 0;
    bit           exp_valid = 0;
    bit           prev_hold = 0;
    bit           prev_rst = 0;
    logic [W-1:0] prev_beat;
    logic [W-1:0] cur_beat;
    logic [W-1:0] in_beat;
    logic [W-1:0] head;
    int           q0;

    assign cur_beat = {bus.m_tdata, bus.m_tlast, bus.m_tkeep, bus.m_tstrb,
                       bus.m_tid, bus.m_tdest, bus.m_tuser};
    assign in_beat  = {bus.push_data, bus.push_last, bus.push_keep, bus.push_strb,
                       bus.push_id, bus.push_dest, bus.push_user};

    // Negedge monitor: sees the values that the coming rising edge will act on.
    always @(negedge clk) begin
        if (armed) begin
            check("level", level, n_push - n_pop);
            check("push_ready", bus.push_ready, (n_push - n_pop) < DEPTH);
            check("pkt_count", pkt_count, model_pkts);
            check("tvalid", bus.m_tvalid, exp_valid);
            if (prev_hold) check("hold_stable", cur_beat, prev_beat);
            if (prev_rst) check("rst_payload", cur_beat, '0);
        end
        prev_rst = reset;
        if (reset) begin
            armed = 1;
            exp_q.delete();
            n_push = 0;
            n_pop = 0;
            model_pkts = '0;
            exp_valid = 0;
            prev_hold = 0;
        end else if (armed) begin
            q0 = exp_q.size();
            exp_valid = (bus.m_tvalid && !bus.m_tready) ||
                        (enable && (q0 - int'(bus.m_tvalid)) > 0);
            prev_hold = bus.m_tvalid && !bus.m_tready;
            prev_beat = cur_beat;
            if (bus.m_tvalid && bus.m_tready) begin
                if (exp_q.size() == 0) begin
                    check("pop_q_size", exp_q.size(), 1);
                end else begin
                    head = exp_q.pop_front();
                    check("beat", cur_beat, head);
                end
                n_pop++;
                if (bus.m_tlast) model_pkts = model_pkts + 1;
            end
            if (bus.push_valid && bus.push_ready) begin
                exp_q.push_back(in_beat);
                n_push++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) bus.m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_beat(input logic [W-1:0] b, input bit gaps);
        bit ok;
        int budget;
        if (gaps) while ($urandom_range(0, 1) == 0) step();
        {bus.push_data, bus.push_last, bus.push_keep, bus.push_strb,
         bus.push_id, bus.push_dest, bus.push_user} = b;
        bus.push_valid = 1'b1;
        budget = 2000;
        do begin
            ok = bus.push_ready;
            step();
            budget--;
        end while (!ok && budget > 0);
        if (!ok) check("push_timeout", bus.push_ready, 1);
        bus.push_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 5000;
        while ((level != 0 || bus.m_tvalid) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("drain_timeout", level, 0);
    endtask

    function automatic logic [W-1:0] mk_beat(input logic last, input logic [7:0] keep,
                                             input logic [7:0] id, input logic [7:0] dest,
                                             input logic [7:0] user);
        logic [63:0] d;
        d = {$urandom, $urandom};
        return {d, last, keep, keep, id, dest, user};
    endfunction

    task automatic push_packet(input int len_bytes, input bit gaps);
        int nb;
        int rem;
        logic [7:0] id, dest, user, keep;
        nb   = (len_bytes + 7) / 8;
        rem  = len_bytes % 8;
        id   = 8'($urandom);
        dest = 8'($urandom);
        user = 8'($urandom);
        for (int i = 0; i < nb; i++) begin
            keep = (i == nb - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
            push_beat(mk_beat(i == nb - 1, keep, id, dest, user), gaps);
        end
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.push_last  = 1'b0;
        bus.push_keep  = '0;
        bus.push_strb  = '0;
        bus.push_id    = '0;
        bus.push_dest  = '0;
        bus.push_user  = '0;
        bus.m_tready   = 1'b0;

        // 1: reset and idle
        repeat (10) step();
        reset = 1'b0;
        repeat (2) step();
        check("rst_tvalid", bus.m_tvalid, 0);
        check("rst_level", level, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_push_ready", bus.push_ready, 1);

        // 2: 100 random packets at full downstream rate
        bus.m_tready = 1'b1;
        for (int p = 0; p < 100; p++) push_packet($urandom_range(64, 1500), 0);
        drain();
        check("pkt_100", pkt_count, 100);

        // 3: fill to DEPTH with downstream stalled, then offer one more beat
        bus.m_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            push_beat(mk_beat(i == DEPTH - 1, 8'hFF, 8'h33, 8'h44, 8'h55), 0);
        check("full_level", level, DEPTH);
        check("full_ready", bus.push_ready, 0);
        {bus.push_data, bus.push_last, bus.push_keep, bus.push_strb,
         bus.push_id, bus.push_dest, bus.push_user} = mk_beat(1, 8'h0F, 8'h66, 8'h77, 8'h88);
        bus.push_valid = 1'b1;
        repeat (3) step();
        bus.push_valid = 1'b0;
        check("full_257_level", level, DEPTH);
        bus.m_tready = 1'b1;
        drain();

        // 4: random ready and push gaps over 1000 beats
        rand_ready = 1;
        for (int i = 0; i < 1000; i++)
            push_beat(mk_beat($urandom_range(0, 7) == 0, 8'($urandom), 8'($urandom),
                              8'($urandom), 8'($urandom)), 1);
        drain();
        rand_ready = 0;
        check("rand_level", level, 0);

        // 5: enable dropped while a beat is held mid-packet
        bus.m_tready = 1'b0;
        push_packet(160, 0);
        repeat (3) step();
        check("en_presented", bus.m_tvalid, 1);
        enable = 1'b0;
        repeat (3) step();
        check("en_held", bus.m_tvalid, 1);
        bus.m_tready = 1'b1;
        step();
        repeat (4) step();
        check("en_pause_valid", bus.m_tvalid, 0);
        check("en_pause_level", level, 19);
        enable = 1'b1;
        drain();

        // 6: reset with 10 beats of an unfinished packet queued
        bus.m_tready = 1'b0;
        for (int i = 0; i < 10; i++) push_beat(mk_beat(0, 8'hFF, 8'h01, 8'h02, 8'h03), 0);
        check("pre_rst_level", level, 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_tvalid", bus.m_tvalid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_pkt_count", pkt_count, 0);
        check("mid_rst_push_ready", bus.push_ready, 1);
        bus.m_tready = 1'b1;
        push_packet(20, 0);
        drain();
        check("post_rst_pkt", pkt_count, 1);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
